// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the multi-stage valid/ready pipeline
//
// Contents:
//   MAX_DEPTH      largest supported number of stages
//   stage_state_t  occupancy state of one stage (EMPTY / HALF / FULL)
//   occ_width()    width of a counter that can hold 0..depth*(skid+1)

package pipe_pkg;

  localparam int MAX_DEPTH = 16;

  typedef enum logic [1:0] {
    STG_EMPTY = 2'd0,
    STG_HALF  = 2'd1,
    STG_FULL  = 2'd2
  } stage_state_t;

  // Each stage holds one beat, or two when it carries a skid entry.
  function automatic int occ_width(input int depth, input int skid);
    return $clog2(depth * (skid + 1) + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/ready pipeline stage, plain register or 2-entry skid buffer
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous discard of held beats
//   up_valid/up_data    beat offered from upstream
//   up_ready            this stage takes the beat on the next edge
//   dn_valid/dn_data    beat offered downstream (always the main entry)
//   dn_ready            downstream takes the beat on the next edge
//   occ                 beats currently held (0..2)

module pipe_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output logic [1:0]       occ
);

  logic             v_m;
  logic             v_s;
  logic [WIDTH-1:0] d_m;
  logic [WIDTH-1:0] d_s;
  logic             accept;
  logic             consume;
  stage_state_t     state;

  always_comb begin
    state = STG_EMPTY;
    if (v_s) begin
      state = STG_FULL;
    end else if (v_m) begin
      state = STG_HALF;
    end
  end

  // Skid mode advertises space purely from the skid flag, so the ready
  // seen upstream is a flop output and never depends on dn_ready.
  // Register mode chains ready combinationally to keep full throughput.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign up_ready = !v_s;
    end else begin : g_reg_ready
      assign up_ready = !v_m || dn_ready;
    end
  endgenerate

  assign accept   = up_valid && up_ready;
  assign consume  = v_m && dn_ready;
  assign dn_valid = v_m;
  assign dn_data  = d_m;
  assign occ      = {1'b0, v_m} + {1'b0, v_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_m <= 1'b0;
      v_s <= 1'b0;
      d_m <= '0;
      d_s <= '0;
    end else if (flush) begin
      v_m <= 1'b0;
      v_s <= 1'b0;
    end else begin
      case (state)
        STG_EMPTY: begin
          if (accept) begin
            v_m <= 1'b1;
            d_m <= up_data;
          end
        end
        STG_HALF: begin
          if (accept && consume) begin
            // main leaves and is replaced in the same edge
            d_m <= up_data;
          end else if (accept && (SKID != 0)) begin
            // downstream stalled: park the new beat behind main
            v_s <= 1'b1;
            d_s <= up_data;
          end else if (consume) begin
            v_m <= 1'b0;
          end
        end
        STG_FULL: begin
          // up_ready is low here, so the only event is a drain of main
          if (consume) begin
            v_s <= 1'b0;
            d_m <= d_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_stage_pipeline.sv
// rtl/multi_stage_pipeline.sv - DEPTH-stage valid/ready pipeline with flush and occupancy
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   flush                  synchronous discard of every held beat
//   in_valid/in_data       upstream beat
//   in_ready               pipeline accepts a beat this cycle
//   out_valid/out_data     downstream beat
//   out_ready              downstream accepts a beat
//   occupancy              number of beats currently held

module multi_stage_pipeline
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int SKID  = 1,
  parameter int CNT_W = occ_width(DEPTH, SKID)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // Index i is the interface feeding stage i; index DEPTH is the output.
  logic             vld [0:DEPTH];
  logic             rdy [0:DEPTH];
  logic [WIDTH-1:0] dat [0:DEPTH];
  logic [1:0]       stg_occ [0:DEPTH-1];
  logic [CNT_W-1:0] occ_sum;
  logic             run_q;

  // Holds in_ready low through reset and releases it one edge later, so
  // the upstream never sees a ready while the stages are still clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Flush blocks both ends so nothing transfers in the discarding cycle.
  assign vld[0]     = in_valid && run_q && !flush;
  assign dat[0]     = in_data;
  assign in_ready   = rdy[0] && run_q && !flush;
  assign rdy[DEPTH] = out_ready && !flush;
  assign out_valid  = vld[DEPTH] && !flush;
  assign out_data   = dat[DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    pipe_stage #(
      .WIDTH (WIDTH),
      .SKID  (SKID)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .up_valid (vld[i]),
      .up_data  (dat[i]),
      .up_ready (rdy[i]),
      .dn_valid (vld[i+1]),
      .dn_data  (dat[i+1]),
      .dn_ready (rdy[i+1]),
      .occ      (stg_occ[i])
    );
  end

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + CNT_W'(stg_occ[i]);
    end
  end

  assign occupancy = occ_sum;

endmodule

// File: tb/tb_multi_stage_pipeline.sv
// tb/tb_multi_stage_pipeline.sv - scoreboard bench for skid and register pipeline builds

module tb_multi_stage_pipeline;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // A: SKID=1 build, B: SKID=0 build
  logic             a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [WIDTH-1:0] a_in_data, a_out_data;
  logic [3:0]       a_occ;
  logic             b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [WIDTH-1:0] b_in_data, b_out_data;
  logic [2:0]       b_occ;

  multi_stage_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .occupancy(a_occ)
  );

  multi_stage_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .occupancy(b_occ)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [WIDTH-1:0] exp_a[$];
  int               cyc_a[$];
  logic [WIDTH-1:0] exp_b[$];
  bit               lat_en = 1'b0;
  int               out_cnt_a = 0;
  int               out_cnt_b = 0;
  int               occ_max_a = 0;
  bit               hold_a = 1'b0;
  logic [WIDTH-1:0] hold_data_a = '0;

  // Monitor A: handshakes sampled mid-cycle, ahead of the edge they take effect on.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_a.delete();
      cyc_a.delete();
      hold_a = 1'b0;
    end else begin
      if (int'(a_occ) > occ_max_a) occ_max_a = int'(a_occ);
      if (a_flush) begin
        exp_a.delete();
        cyc_a.delete();
      end else if (hold_a) begin
        check("a_hold_valid", a_out_valid, 1);
        check("a_hold_data", a_out_data, hold_data_a);
      end
      if (a_in_valid && a_in_ready) begin
        exp_a.push_back(a_in_data);
        cyc_a.push_back(cyc);
      end
      if (a_out_valid && a_out_ready) begin
        out_cnt_a++;
        if (exp_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_beat: got 0x%0h, expected no beat", a_out_data);
        end else begin
          int lat;
          check("a_out_data", a_out_data, exp_a.pop_front());
          lat = cyc - cyc_a.pop_front();
          if (lat_en) check("a_latency", lat, DEPTH);
        end
      end
      hold_a      = a_out_valid && !a_out_ready;
      hold_data_a = a_out_data;
    end
  end

  // Monitor B
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_b.delete();
    end else begin
      if (b_in_valid && b_in_ready) exp_b.push_back(b_in_data);
      if (b_out_valid && b_out_ready) begin
        out_cnt_b++;
        if (exp_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_beat: got 0x%0h, expected no beat", b_out_data);
        end else begin
          check("b_out_data", b_out_data, exp_b.pop_front());
        end
      end
    end
  end

  task automatic send_a(input logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b1;
    a_in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("a_send_accept", ok, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_drain_a();
    int i = 0;
    while (exp_a.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(negedge clk);
    check("a_drain", exp_a.size(), 0);
  endtask

  task automatic wait_drain_b();
    int i = 0;
    while (exp_b.size() != 0 && i < 200) begin
      @(posedge clk);
      i++;
    end
    @(negedge clk);
    check("b_drain", exp_b.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    a_flush = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;

    // Reset state
    #2;
    check("rst_a_in_ready", a_in_ready, 0);
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_occ", a_occ, 0);
    check("rst_b_in_ready", b_in_ready, 0);
    check("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_a_in_ready", a_in_ready, 1);
    check("rel_b_in_ready", b_in_ready, 1);
    check("rel_a_occ", a_occ, 0);

    // Single-beat latency
    a_out_ready = 1'b1;
    lat_en      = 1'b1;
    occ_max_a   = 0;
    base        = out_cnt_a;
    send_a(32'hA5A5_0001);
    wait_drain_a();
    check("t1_out_count", out_cnt_a - base, 1);
    check("t1_occ_peak", occ_max_a, 1);

    // Back-to-back 0x1..0x20
    base = out_cnt_a;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'(i + 1);
      @(negedge clk);
      check("t2_in_ready", a_in_ready, 1);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_drain_a();
    check("t2_out_count", out_cnt_a - base, 32);

    // Stall and fill to capacity 8
    lat_en      = 1'b0;
    a_out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'h100 + 32'(n);
      @(negedge clk);
      if (a_in_ready) n++;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    check("t3_accepted", n, 8);
    check("t3_in_ready", a_in_ready, 0);
    check("t3_occ", a_occ, 8);
    check("t3_out_valid", a_out_valid, 1);
    check("t3_out_data", a_out_data, 32'h100);
    repeat (3) @(posedge clk);
    #1;
    check("t3_out_data_stable", a_out_data, 32'h100);
    base        = out_cnt_a;
    a_out_ready = 1'b1;
    wait_drain_a();
    check("t3_out_count", out_cnt_a - base, 8);

    // Flush with five beats held
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'h300 + 32'(i);
      @(negedge clk);
      check("t4_fill_ready", a_in_ready, 1);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    check("t4_occ_before", a_occ, 5);
    @(posedge clk); #1;
    a_flush    = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 32'hDEAD_BEEF;
    #1;
    check("t4_flush_in_ready", a_in_ready, 0);
    check("t4_flush_out_valid", a_out_valid, 0);
    @(posedge clk); #1;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("t4_occ_after", a_occ, 0);
    check("t4_out_valid_after", a_out_valid, 0);
    a_out_ready = 1'b1;
    lat_en      = 1'b1;
    base        = out_cnt_a;
    send_a(32'h0000_0077);
    wait_drain_a();
    check("t4_out_count", out_cnt_a - base, 1);

    // Asynchronous reset mid-stream
    lat_en      = 1'b0;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1;
      a_in_data  = 32'h400 + 32'(i);
      @(negedge clk);
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    #1;
    check("t5_occ_before", a_occ, 3);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_out_valid", a_out_valid, 0);
    check("t5_rst_occ", a_occ, 0);
    check("t5_rst_in_ready", a_in_ready, 0);
    check("t5_rst_out_data", a_out_data, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_rel_in_ready", a_in_ready, 1);
    a_out_ready = 1'b1;
    base        = out_cnt_a;
    repeat (10) @(posedge clk);
    #1;
    check("t5_no_stale", out_cnt_a - base, 0);
    send_a(32'h0000_0055);
    wait_drain_a();
    check("t5_out_count", out_cnt_a - base, 1);

    // Register build: capacity 4, combinational ready
    b_out_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1;
      b_in_data  = 32'h200 + 32'(n);
      @(negedge clk);
      if (b_in_ready) n++;
    end
    check("b_accepted", n, 4);
    check("b_full_in_ready", b_in_ready, 0);
    check("b_occ_full", b_occ, 4);
    check("b_out_data_head", b_out_data, 32'h200);
    base = out_cnt_b;
    @(posedge clk); #1;
    b_out_ready = 1'b1;
    #1;
    check("b_comb_ready", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    wait_drain_b();
    check("b_out_count", out_cnt_b - base, 5);
    check("b_occ_empty", b_occ, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
